// File: rtl/y86_regfile_sb_if.sv
// Decode / execute / writeback / debug bundle for the Y86 register file with scoreboard.
// master = pipeline side driving decode and writeback; slave = register file.
interface y86_regfile_sb_if #(
    parameter int DATA_W = 64
);
    logic              d_valid;
    logic [3:0]        d_srcA;
    logic [3:0]        d_srcB;
    logic [3:0]        d_dstE;
    logic [3:0]        d_dstM;
    logic              d_ready;
    logic              e_valid;
    logic [DATA_W-1:0] e_valA;
    logic [DATA_W-1:0] e_valB;
    logic              w_validE;
    logic [3:0]        w_dstE;
    logic [DATA_W-1:0] w_valE;
    logic              w_validM;
    logic [3:0]        w_dstM;
    logic [DATA_W-1:0] w_valM;
    logic [3:0]        dbg_sel;
    logic [DATA_W-1:0] dbg_val;
    logic              err;

    modport master (
        output d_valid, d_srcA, d_srcB, d_dstE, d_dstM,
        output w_validE, w_dstE, w_valE, w_validM, w_dstM, w_valM, dbg_sel,
        input  d_ready, e_valid, e_valA, e_valB, dbg_val, err
    );

    modport slave (
        input  d_valid, d_srcA, d_srcB, d_dstE, d_dstM,
        input  w_validE, w_dstE, w_valE, w_validM, w_dstM, w_valM, dbg_sel,
        output d_ready, e_valid, e_valA, e_valB, dbg_val, err
    );
endinterface

// File: rtl/y86_regfile_sb.sv
// Y86 register file with two bypassed read ports, two write ports and per-register pending-write scoreboard.
// Define REGFILE_ERR_EN to build the sticky err checker; otherwise err is tied low.
module y86_regfile_sb #(
    parameter int                DATA_W   = 64,
    parameter int                NUM_REGS = 15,
    parameter int                RSP_ID   = 4,
    parameter logic [DATA_W-1:0] RSP_INIT = '0,
    parameter int                MAX_PEND = 3
) (
    input  logic             clk,
    input  logic             reset,
    y86_regfile_sb_if.slave  bus
);
    localparam int         PEND_W = $clog2(MAX_PEND + 1);
    localparam logic [3:0] RNONE  = 4'hF;

    logic [DATA_W-1:0] regs     [NUM_REGS];
    logic [PEND_W-1:0] pend     [NUM_REGS];
    logic [PEND_W-1:0] pend_nxt [NUM_REGS];
    int                wb_cnt   [NUM_REGS];
    int                iss_cnt  [NUM_REGS];

    logic              wbE_ok, wbM_ok, accept;
    logic              stallA, stallB, satE, satM;
    logic [DATA_W-1:0] opA, opB;
    logic              vld_p1;
    logic [DATA_W-1:0] valA_p1, valB_p1;

    function automatic logic id_ok(input logic [3:0] id);
        return (id != RNONE) && (int'(id) < NUM_REGS);
    endfunction

    // Counter arithmetic never goes negative and never exceeds MAX_PEND.
    function automatic logic [PEND_W-1:0] sat_pend(input int v);
        if (v < 0)        return '0;
        if (v > MAX_PEND) return PEND_W'(MAX_PEND);
        return PEND_W'(v);
    endfunction

    function automatic logic [DATA_W-1:0] bypass(
        input logic [3:0] s, input logic [DATA_W-1:0] rf,
        input logic m_ok, input logic [3:0] m_id, input logic [DATA_W-1:0] m_val,
        input logic e_ok, input logic [3:0] e_id, input logic [DATA_W-1:0] e_val);
        if (!id_ok(s))            return '0;
        if (m_ok && m_id == s)    return m_val;
        if (e_ok && e_id == s)    return e_val;
        return rf;
    endfunction

    assign wbE_ok = bus.w_validE && id_ok(bus.w_dstE);
    assign wbM_ok = bus.w_validM && id_ok(bus.w_dstM);

    always_comb begin
        for (int r = 0; r < NUM_REGS; r++) begin
            wb_cnt[r] = int'(wbE_ok && bus.w_dstE == 4'(r)) + int'(wbM_ok && bus.w_dstM == 4'(r));
        end
    end

    // A source stalls only while writes remain outstanding after this cycle's writebacks.
    always_comb begin
        stallA = 1'b0;
        stallB = 1'b0;
        satE   = 1'b0;
        satM   = 1'b0;
        if (id_ok(bus.d_srcA))
            stallA = (int'(pend[bus.d_srcA]) - wb_cnt[bus.d_srcA]) > 0;
        if (id_ok(bus.d_srcB))
            stallB = (int'(pend[bus.d_srcB]) - wb_cnt[bus.d_srcB]) > 0;
        if (id_ok(bus.d_dstE))
            satE = (int'(pend[bus.d_dstE]) == MAX_PEND) && (wb_cnt[bus.d_dstE] == 0);
        if (id_ok(bus.d_dstM))
            satM = (int'(pend[bus.d_dstM]) == MAX_PEND) && (wb_cnt[bus.d_dstM] == 0);
    end

    assign bus.d_ready = !(stallA || stallB || satE || satM);
    assign accept      = bus.d_valid && bus.d_ready;

    always_comb begin
        for (int r = 0; r < NUM_REGS; r++) begin
            iss_cnt[r]  = accept ? int'(bus.d_dstE == 4'(r)) + int'(bus.d_dstM == 4'(r)) : 0;
            pend_nxt[r] = sat_pend(int'(pend[r]) + iss_cnt[r] - wb_cnt[r]);
        end
    end

    assign opA = bypass(bus.d_srcA, id_ok(bus.d_srcA) ? regs[bus.d_srcA] : '0,
                        wbM_ok, bus.w_dstM, bus.w_valM, wbE_ok, bus.w_dstE, bus.w_valE);
    assign opB = bypass(bus.d_srcB, id_ok(bus.d_srcB) ? regs[bus.d_srcB] : '0,
                        wbM_ok, bus.w_dstM, bus.w_valM, wbE_ok, bus.w_dstE, bus.w_valE);

    assign bus.dbg_val = id_ok(bus.dbg_sel) ? regs[bus.dbg_sel] : '0;

    // Decode -> execute stage boundary; M write is issued last so it wins on a shared ID.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                regs[r] <= (r == RSP_ID) ? RSP_INIT : '0;
                pend[r] <= '0;
            end
            vld_p1  <= 1'b0;
            valA_p1 <= '0;
            valB_p1 <= '0;
        end else begin
            for (int r = 0; r < NUM_REGS; r++) pend[r] <= pend_nxt[r];
            if (wbE_ok) regs[bus.w_dstE] <= bus.w_valE;
            if (wbM_ok) regs[bus.w_dstM] <= bus.w_valM;
            vld_p1 <= accept;
            if (accept) begin
                valA_p1 <= opA;
                valB_p1 <= opB;
            end
        end
    end

    assign bus.e_valid = vld_p1;
    assign bus.e_valA  = valA_p1;
    assign bus.e_valB  = valB_p1;

`ifdef REGFILE_ERR_EN
    logic err_q, err_hit;

    always_comb begin
        err_hit = 1'b0;
        if (wbE_ok && pend[bus.w_dstE] == '0) err_hit = 1'b1;
        if (wbM_ok && pend[bus.w_dstM] == '0) err_hit = 1'b1;
        if (bus.w_validE && !id_ok(bus.w_dstE) && bus.w_dstE != RNONE) err_hit = 1'b1;
        if (bus.w_validM && !id_ok(bus.w_dstM) && bus.w_dstM != RNONE) err_hit = 1'b1;
        if (accept && bus.d_dstE == bus.d_dstM && bus.d_dstE != RNONE) err_hit = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset)        err_q <= 1'b0;
        else if (err_hit) err_q <= 1'b1;
    end

    assign bus.err = err_q;
`else
    assign bus.err = 1'b0;
`endif
endmodule
